// File: rtl/adder.sv
// adder: registered WIDTH-bit adder built from 4-bit carry-lookahead groups.
// Define ADDER_SUB_EN to add the Sub port (Sub=1 gives In1 - In2 as In1 + ~In2 + 1).
module adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
`ifdef ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic [WIDTH-1:0] Out,
    output logic             Carry,
    output logic             Overflow
);
    localparam int NG = WIDTH / 4;
    logic             cin;
    logic [WIDTH-1:0] b, g, p;
    logic [NG-1:0]    gg, gp;
    logic [WIDTH:0]   c;
`ifdef ADDER_SUB_EN
    assign cin = Sub;
`else
    assign cin = 1'b0;
`endif
    assign b = In2 ^ {WIDTH{cin}};
    assign g = In1 & b;
    assign p = In1 ^ b;
    for (genvar i = 0; i < NG; i++) begin : grp
        assign gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                     | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
        assign gp[i] = &p[4*i+3:4*i];
    end
    // Bit carries inside a group look ahead from the group carry-in only; groups ripple.
    always_comb begin
        c = '0;
        c[0] = cin;
        for (int i = 0; i < NG; i++) begin
            c[4*i+1] = g[4*i] | (p[4*i] & c[4*i]);
            c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & c[4*i]);
            c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
                     | (p[4*i+2] & p[4*i+1] & p[4*i] & c[4*i]);
            c[4*i+4] = gg[i] | (gp[i] & c[4*i]);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Out      <= '0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            Out      <= p ^ c[WIDTH-1:0];
            Carry    <= c[WIDTH];
            Overflow <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
endmodule

// File: tb/tb_adder.sv
// tb_adder: random and directed checks of adder against an integer-arithmetic model.
module tb_adder;
    localparam int W = 32;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] in1 = '0, in2 = '0, out;
    logic         carry, overflow;
    logic [W-1:0] q1 = '0, q2 = '0;
    logic         qs = 1'b0, qr = 1'b0;
    bit           check_en = 1'b0;
    int           n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    adder #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .In1(in1),
        .In2(in2),
`ifdef ADDER_SUB_EN
        .Sub(sub),
`endif
        .Out(out),
        .Carry(carry),
        .Overflow(overflow)
    );

    // Returns {overflow, carry, sum} from exact signed and unsigned integer results.
    function automatic logic [W+1:0] model(logic [W-1:0] a, logic [W-1:0] bb, logic s);
        longint sa, sb, ua, ub, t, u, lim;
        logic   cy, ov;
        sa  = {{(64-W){a[W-1]}}, a};
        sb  = {{(64-W){bb[W-1]}}, bb};
        ua  = {{(64-W){1'b0}}, a};
        ub  = {{(64-W){1'b0}}, bb};
        lim = 64'sd1 <<< (W - 1);
        t   = s ? sa - sb : sa + sb;
        u   = s ? ua - ub : ua + ub;
        cy  = s ? (ua >= ub) : (u >= (lim <<< 1));
        ov  = (t >= lim) || (t < -lim);
        return {ov, cy, u[W-1:0]};
    endfunction

    task automatic check(string name, logic [W+1:0] act, logic [W+1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got ov=%b c=%b out=%h, want ov=%b c=%b out=%h",
                     name, act[W+1], act[W], act[W-1:0], exp[W+1], exp[W], exp[W-1:0]);
        end
    endtask

    task automatic directed(string name, logic [W-1:0] a, logic [W-1:0] bb, logic s, logic [W+1:0] lit);
        @(negedge clk);
        in1 = a;
        in2 = bb;
        sub = s;
        @(posedge clk);
        #1;
        check(name, {overflow, carry, out}, lit);
        check({name, "_model"}, model(a, bb, s), lit);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] one = 1;
        case ($urandom % 6)
            0: return '0;
            1: return '1;
            2: return one << (W - 1);
            3: return ~(one << (W - 1));
            4: return one;
            default: return W'($urandom);
        endcase
    endfunction

    always @(posedge clk) begin
        q1 <= in1;
        q2 <= in2;
        qs <= sub;
        qr <= rst;
    end

    always @(negedge clk)
        if (check_en)
            check("stream", {overflow, carry, out}, qr ? '0 : model(q1, q2, qs));

    initial begin
        #2 rst = 1'b1;
        #1 check("reset_async", {overflow, carry, out}, '0);
        @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;
        directed("add_5_7",    32'd5,        32'd7,        1'b0, {2'b00, 32'h0000000C});
        directed("add_neg",    32'hFFFFFFF6, 32'hFFFFFFFB, 1'b0, {2'b01, 32'hFFFFFFF1});
        directed("pos_ovf",    32'h7FFFFFFF, 32'd1,        1'b0, {2'b10, 32'h80000000});
        directed("neg_ovf",    32'h80000000, 32'hFFFFFFFF, 1'b0, {2'b11, 32'h7FFFFFFF});
        directed("wrap_zero",  32'hFFFFFFFF, 32'd1,        1'b0, {2'b01, 32'h00000000});
`ifdef ADDER_SUB_EN
        directed("sub_3_5",    32'd3,        32'd5,        1'b1, {2'b00, 32'hFFFFFFFE});
        directed("sub_ovf",    32'h80000000, 32'd1,        1'b1, {2'b11, 32'h7FFFFFFF});
`endif
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in1 = pick();
            in2 = pick();
`ifdef ADDER_SUB_EN
            sub = 1'($urandom);
`endif
        end
        // Reset asserted between edges must clear outputs at once and hold them cleared.
        @(negedge clk);
        check_en = 1'b0;
        in1 = 32'd5;
        in2 = 32'd7;
        sub = 1'b0;
        @(posedge clk);
        #1 check("pre_reset", {overflow, carry, out}, {2'b00, 32'h0000000C});
        #2 rst = 1'b1;
        #1 check("reset_mid", {overflow, carry, out}, '0);
        in1 = 32'h7FFFFFFF;
        in2 = 32'd1;
        @(posedge clk);
        #1 check("reset_hold", {overflow, carry, out}, '0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 check("after_reset", {overflow, carry, out}, {2'b10, 32'h80000000});
        @(negedge clk);
        check_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            in1 = pick();
            in2 = pick();
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
